// File: rtl/add_round_key_stage.sv
// AES AddRoundKey stage: XORs the state with the round key into a 2-entry skid FIFO.
// Optional macro ARK_ROUND_CHECK_EN drops out-of-range round beats and raises sticky err.
module add_round_key_stage #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    input  logic [3:0]   in_round,
    input  logic [127:0] key_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic [3:0]   out_round,
    output logic         out_last
`ifdef ARK_ROUND_CHECK_EN
    ,
    output logic         err
`endif
);

    localparam logic [3:0] NR_RND = 4'(NR);

    logic [1:0]   count_q, count_d;
    logic [127:0] head_data_q, head_data_d, tail_data_q, tail_data_d;
    logic [3:0]   head_round_q, head_round_d, tail_round_q, tail_round_d;
    logic         head_last_q, head_last_d, tail_last_q, tail_last_d;

    logic         push, pop, store;
    logic [127:0] new_data;
    logic         new_last;

    assign in_ready  = (count_q != 2'd2);
    assign out_valid = (count_q != 2'd0);
    assign out_data  = head_data_q;
    assign out_round = head_round_q;
    assign out_last  = head_last_q;

    assign push     = in_valid && in_ready;
    assign pop      = out_valid && out_ready;
    assign new_data = in_data ^ key_data;
    assign new_last = (in_round == NR_RND);

`ifdef ARK_ROUND_CHECK_EN
    logic err_q, err_d, bad_round;
    assign bad_round = (in_round == 4'd0) || (in_round > NR_RND);
    // Out-of-range beats still complete the handshake; they are just not stored.
    assign store = push && !bad_round;
    assign err_d = err_q || (push && bad_round);
    assign err   = err_q;
`else
    assign store = push;
`endif

    always_comb begin
        count_d      = count_q;
        head_data_d  = head_data_q;
        head_round_d = head_round_q;
        head_last_d  = head_last_q;
        tail_data_d  = tail_data_q;
        tail_round_d = tail_round_q;
        tail_last_d  = tail_last_q;
        if (pop) begin
            head_data_d  = tail_data_q;
            head_round_d = tail_round_q;
            head_last_d  = tail_last_q;
        end
        if (store) begin
            // After a pop at count 1 the head slot is free again, so the new beat lands there.
            if (count_q == 2'd0 || (pop && count_q == 2'd1)) begin
                head_data_d  = new_data;
                head_round_d = in_round;
                head_last_d  = new_last;
            end else begin
                tail_data_d  = new_data;
                tail_round_d = in_round;
                tail_last_d  = new_last;
            end
        end
        if (store && !pop) begin
            count_d = count_q + 2'd1;
        end else if (!store && pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_q      <= 2'd0;
            head_data_q  <= '0;
            head_round_q <= '0;
            head_last_q  <= 1'b0;
            tail_data_q  <= '0;
            tail_round_q <= '0;
            tail_last_q  <= 1'b0;
        end else begin
            count_q      <= count_d;
            head_data_q  <= head_data_d;
            head_round_q <= head_round_d;
            head_last_q  <= head_last_d;
            tail_data_q  <= tail_data_d;
            tail_round_q <= tail_round_d;
            tail_last_q  <= tail_last_d;
        end
    end

`ifdef ARK_ROUND_CHECK_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end
`endif

endmodule

// File: tb/tb_add_round_key_stage.sv
// Directed and randomized bench for add_round_key_stage against a queue-based reference model.
module tb_add_round_key_stage;

    localparam int NR = 10;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_data;
    logic [3:0]   in_round;
    logic [127:0] key_data;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_data;
    logic [3:0]   out_round;
    logic         out_last;
`ifdef ARK_ROUND_CHECK_EN
    logic         err;
    logic         err_exp = 1'b0;
`endif

    add_round_key_stage #(.NR(NR)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_round(in_round), .key_data(key_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_round(out_round), .out_last(out_last)
`ifdef ARK_ROUND_CHECK_EN
        , .err(err)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] d;
        logic [3:0]   r;
    } beat_t;

    beat_t q[$];
    int total = 0;
    int bad = 0;
    int accepted = 0;
    int delivered = 0;
    int valid_run = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the model, then advance the model.
    task automatic cyc(input logic v, input logic [127:0] d, input logic [127:0] k,
                       input logic [3:0] r, input logic ordy);
        logic acc, del;
        in_valid = v; in_data = d; key_data = k; in_round = r; out_ready = ordy;
        #1;
        chk("in_ready", 128'(in_ready), 128'(q.size() < 2));
        chk("out_valid", 128'(out_valid), 128'(q.size() != 0));
        if (q.size() != 0) begin
            chk("out_data", out_data, q[0].d);
            chk("out_round", 128'(out_round), 128'(q[0].r));
            chk("out_last", 128'(out_last), 128'(q[0].r == 4'(NR)));
        end
`ifdef ARK_ROUND_CHECK_EN
        chk("err", 128'(err), 128'(err_exp));
`endif
        acc = v && (q.size() < 2);
        del = (q.size() != 0) && ordy;
        valid_run = out_valid ? valid_run + 1 : 0;
        @(posedge clk);
        if (del) begin
            void'(q.pop_front());
            delivered++;
        end
        if (acc) begin
            accepted++;
`ifdef ARK_ROUND_CHECK_EN
            if (r == 4'd0 || r > 4'(NR)) err_exp = 1'b1;
            else q.push_back('{d ^ k, r});
`else
            q.push_back('{d ^ k, r});
`endif
        end
        #1;
    endtask

    initial begin
        logic [127:0] rd, rk;
        int cycles;
        int max_run;
        rst = 1'b1; in_valid = 1'b0; in_data = '0; in_round = '0; key_data = '0; out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
        chk("rst_out_data", out_data, 128'h0);
        chk("rst_out_round", 128'(out_round), 128'h0);
        chk("rst_out_last", 128'(out_last), 128'h0);
        chk("rst_in_ready", 128'(in_ready), 128'(1'b1));
`ifdef ARK_ROUND_CHECK_EN
        chk("rst_err", 128'(err), 128'h0);
`endif
        @(posedge clk); #1;
        rst = 1'b0;

        // FIPS-197 Appendix B, round 1
        cyc(1'b1, 128'h046681e5e0cb199a48f8d37a2806264c, 128'ha0fafe1788542cb123a339392a6c7605, 4'd1, 1'b1);
        chk("fips_valid", 128'(out_valid), 128'(1'b1));
        chk("fips_data", out_data, 128'ha49c7ff2689f352b6b5bea43026a5049);
        chk("fips_round", 128'(out_round), 128'd1);
        chk("fips_last", 128'(out_last), 128'd0);
        cyc(1'b0, '0, '0, 4'd0, 1'b1);

        // Backpressure: third beat must be held until the consumer drains
        cyc(1'b1, 128'h11, 128'h01, 4'd1, 1'b0);
        cyc(1'b1, 128'h22, 128'h02, 4'd2, 1'b0);
        chk("full_in_ready", 128'(in_ready), 128'(1'b0));
        chk("full_head_round", 128'(out_round), 128'd1);
        cyc(1'b1, 128'h33, 128'h03, 4'd3, 1'b0);
        cyc(1'b1, 128'h33, 128'h03, 4'd3, 1'b1);
        cyc(1'b1, 128'h33, 128'h03, 4'd3, 1'b1);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 4'd0, 1'b1);
        chk("bp_drained", 128'(q.size()), 128'd0);

        // Streaming rounds 1..10 at full rate
        max_run = 0;
        for (int i = 1; i <= 10; i++) begin
            cyc(1'b1, {$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom}, 4'(i), 1'b1);
            if (valid_run > max_run) max_run = valid_run;
        end
        for (int i = 0; i < 3; i++) begin
            cyc(1'b0, '0, '0, 4'd0, 1'b1);
            if (valid_run > max_run) max_run = valid_run;
        end
        chk("stream_run", 128'(max_run), 128'd10);

        // Asynchronous reset with two beats stored
        cyc(1'b1, 128'haa, 128'h0f, 4'd4, 1'b0);
        cyc(1'b1, 128'hbb, 128'hf0, 4'd5, 1'b0);
        in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("mid_rst_valid", 128'(out_valid), 128'(1'b0));
        chk("mid_rst_data", out_data, 128'h0);
        chk("mid_rst_round", 128'(out_round), 128'h0);
        q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        chk("post_rst_ready", 128'(in_ready), 128'(1'b1));
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, '0, 4'd0, 1'b1);

`ifdef ARK_ROUND_CHECK_EN
        cyc(1'b1, 128'h5, 128'h6, 4'd11, 1'b1);
        cyc(1'b1, 128'h7, 128'h9, 4'd2, 1'b1);
        cyc(1'b0, '0, '0, 4'd0, 1'b1);
        chk("range_err", 128'(err), 128'(1'b1));
`endif

        // Random traffic with random backpressure
        accepted = 0;
        delivered = 0;
        cycles = 0;
        while (accepted < 1000 && cycles < 20000) begin
            rd = {$urandom, $urandom, $urandom, $urandom};
            rk = {$urandom, $urandom, $urandom, $urandom};
            cyc(($urandom_range(0, 3) != 0), rd, rk, 4'($urandom_range(1, NR)), ($urandom_range(0, 2) != 0));
            cycles++;
        end
        chk("rand_budget", 128'(accepted >= 1000), 128'(1'b1));
        for (int i = 0; i < 4; i++) cyc(1'b0, '0, '0, 4'd0, 1'b1);
        chk("rand_empty", 128'(out_valid), 128'(1'b0));
        chk("rand_count", 128'(delivered), 128'(accepted));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/add_round_key_stage.md
ADD_ROUND_KEY_STAGE -- requirements
Module: add_round_key_stage

Interface
REQ-001 Parameter: NR, default 10, index of the final AES round; out_last asserts for beats tagged with this round.
REQ-002 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-003 Port: rst  input  1  asynchronous, active-high reset.
REQ-004 Port: in_valid  input  1  upstream beat present; aligned with mixcolumns output, one cycle after that stage's data_in.
REQ-005 Port: in_ready  output  1  stage can accept a beat this cycle.
REQ-006 Port: in_data  input  128  state word from mixcolumns, byte 0 at [127:120].
REQ-007 Port: in_round  input  4  round number of the beat.
REQ-008 Port: key_data  input  128  round key, sampled with the beat.
REQ-009 Port: out_valid  output  1  output beat present.
REQ-010 Port: out_ready  input  1  downstream accepts the beat.
REQ-011 Port: out_data  output  128  in_data XOR key_data.
REQ-012 Port: out_round  output  4  round tag carried with the beat.
REQ-013 Port: out_last  output  1  out_round == NR.
REQ-014 Port: err  output  1  sticky round-range error; present only with ARK_ROUND_CHECK_EN.

Function
REQ-015 Beat accepted on in_valid && in_ready; beat delivered on out_valid && out_ready.
REQ-016 Storage: 2-entry FIFO (head, tail registers) plus 2-bit count, range 0..2.
REQ-017 Stored word = in_data ^ key_data, computed before the register; no XOR on the output path.
REQ-018 in_ready = (count < 2), from registered count only; never a function of out_ready.
REQ-019 out_valid = (count != 0); out_data/out_round/out_last driven from head entry.
REQ-020 Latency: accepted beat visible on out_valid the next cycle when count was 0.
REQ-021 Push only: count+1; push into head if count 0, else tail.
REQ-022 Pop only: tail moves to head, count-1.
REQ-023 Push and pop same cycle: count unchanged; at count 1 new beat goes to head; at count 2 not possible (in_ready low).
REQ-024 Order strictly preserved; no beat dropped or duplicated under any out_ready pattern.
REQ-025 Output fields hold stable while out_valid && !out_ready.
REQ-026 Sustained throughput one beat/cycle with out_ready held high.

Reset
REQ-027 rst asserted: count=0, out_valid=0, in_ready=1 after reset, out_data=0, out_round=0, out_last=0, err=0, immediately (asynchronous).
REQ-028 Reset mid-operation discards all stored beats; no partial beat emitted after release.
REQ-029 First accept possible on the first rising clk edge after rst deasserts.

Configuration
REQ-030 Macro ARK_ROUND_CHECK_EN defined: beat with in_round == 0 or in_round > NR is consumed (in_ready handshake completes) but not stored; err sets and holds until rst.
REQ-031 Macro undefined: no range check, every accepted beat stored, err port absent.

Verification
REQ-032 FIPS-197 B: in_data 046681e5e0cb199a48f8d37a2806264c, key a0fafe1788542cb123a339392a6c7605, round 1 -> next cycle out_data a49c7ff2689f352b6b5bea43026a5049, out_round 1, out_last 0.
REQ-033 out_ready=0, push 3 beats rounds 1,2,3 back-to-back -> in_ready low after 2nd accept; 3rd held; out_ready=1 -> rounds 1,2,3 delivered in order.
REQ-034 Continuous in_valid/out_ready 10 beats rounds 1..10 -> 10 consecutive out_valid cycles, out_last only on round 10.
REQ-035 count=2, assert rst for 1 cycle mid-stream -> out_valid 0 immediately, in_ready 1 after release, no stale beat output.
REQ-036 ARK_ROUND_CHECK_EN: beat with in_round 11 -> no output beat, err=1 held; following round-2 beat delivered normally.
REQ-037 Random out_ready backpressure, 1000 beats -> output stream equals XOR reference model, zero loss.
